// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state type and legality helpers for the load/store controller
//
// Contents:
//   LANES            number of byte lanes in a data word
//   OP_*             MemOp encodings (byte/half/word, signed/unsigned)
//   state_t          controller states IDLE, MREQ, MWAIT, RESP
//   op_illegal       1 when rd/wr/op do not form a supported operation
//   op_misaligned    1 when the byte offset does not match the access size
//   op_force_align   offset rounded down to the natural alignment of the size
package lsu_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MREQ,
    ST_MWAIT,
    ST_RESP
  } state_t;

  function automatic logic op_illegal(input logic rd, input logic wr, input logic [2:0] op);
    logic bad;
    bad = (rd == wr);
    case (op)
      OP_B, OP_H, OP_W: ;
      OP_BU, OP_HU:     if (wr) bad = 1'b1;  // no unsigned stores
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] op_force_align(input logic [2:0] op, input logic [1:0] off);
    logic [1:0] res;
    case (op[1:0])
      2'b01:   res = {off[1], 1'b0};
      2'b10:   res = 2'b00;
      default: res = off;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
//
// Ports:
//   op      in   3   MemOp encoding (size in [1:0], unsigned in [2])
//   off     in   2   byte offset within the word
//   wdata   in  32   store data, low bits significant
//   rdata   in  32   little-endian memory read word
//   mask    out  4   byte-lane write mask
//   wlanes  out 32   store data replicated into every lane of its size
//   rext    out 32   selected load field, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [1:0]       off,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] mask,
  output logic [31:0]      wlanes,
  output logic [31:0]      rext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  always_comb begin
    byte_v = 8'h00;
    case (off)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    sx     = ~op[2];

    mask   = '0;
    wlanes = '0;
    rext   = '0;
    case (op[1:0])
      2'b00: begin
        mask   = 4'b0001 << off;
        wlanes = {4{wdata[7:0]}};
        rext   = {{24{byte_v[7] & sx}}, byte_v};
      end
      2'b01: begin
        mask   = 4'b0011 << off;
        wlanes = {2{wdata[15:0]}};
        rext   = {{16{half_v[15] & sx}}, half_v};
      end
      default: begin
        mask   = {LANES{1'b1}};
        wlanes = wdata;
        rext   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multi-cycle load/store controller between execute and the data memory port
//
// Build option: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses answer Err=1 without touching memory
//   undefined -> offset is rounded down to the natural alignment and the access proceeds
//
// Ports:
//   Clk, RstN                     clock, asynchronous active-low reset
//   ReqValid/ReqReady             execute-side handshake (ready only in IDLE)
//   Addr, MemRd, MemWr, MemOp, WData   operation captured on accept
//   MReqValid/MReqReady           memory request handshake
//   MAddr, MWen, MWMask, MWData   word address, write flag, lane mask, steered data
//   MRespValid, MRData            one-cycle memory response and read word
//   RespValid/RespReady           writeback handshake
//   RData, Err                    extended load data (0 for stores/errors), error flag
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [AW-1:0] Addr,
  input  logic          MemRd,
  input  logic          MemWr,
  input  logic [2:0]    MemOp,
  input  logic [DW-1:0] WData,
  output logic          MReqValid,
  input  logic          MReqReady,
  output logic [AW-1:0] MAddr,
  output logic          MWen,
  output logic [3:0]    MWMask,
  output logic [DW-1:0] MWData,
  input  logic          MRespValid,
  input  logic [DW-1:0] MRData,
  output logic          RespValid,
  input  logic          RespReady,
  output logic [DW-1:0] RData,
  output logic          Err
);

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] off_q;
  logic       rd_q;

  logic [1:0] eff_off;
  logic       req_err;

`ifdef LSU_MISALIGN_CHECK_EN
  assign eff_off = Addr[1:0];
  assign req_err = op_illegal(MemRd, MemWr, MemOp) | op_misaligned(MemOp, Addr[1:0]);
`else
  assign eff_off = op_force_align(MemOp, Addr[1:0]);
  assign req_err = op_illegal(MemRd, MemWr, MemOp);
`endif

  // One steering unit serves both directions: in IDLE it steers the incoming
  // store, afterwards it extracts from MRData using the captured op/offset.
  logic [2:0]  al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_mask;
  logic [31:0] al_wlanes;
  logic [31:0] al_rext;

  assign al_op  = (state == ST_IDLE) ? MemOp : op_q;
  assign al_off = (state == ST_IDLE) ? eff_off : off_q;

  lsu_align u_align (
    .op     (al_op),
    .off    (al_off),
    .wdata  (WData),
    .rdata  (MRData),
    .mask   (al_mask),
    .wlanes (al_wlanes),
    .rext   (al_rext)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state     <= ST_IDLE;
      op_q      <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 1'b0;
      ReqReady  <= 1'b0;
      MReqValid <= 1'b0;
      MAddr     <= '0;
      MWen      <= 1'b0;
      MWMask    <= 4'b0000;
      MWData    <= '0;
      RespValid <= 1'b0;
      RData     <= '0;
      Err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ReqReady <= 1'b1;
          if (ReqValid && ReqReady) begin
            ReqReady <= 1'b0;
            op_q     <= MemOp;
            off_q    <= eff_off;
            rd_q     <= MemRd;
            if (req_err) begin
              state     <= ST_RESP;
              RespValid <= 1'b1;
              Err       <= 1'b1;
              RData     <= '0;
            end else begin
              state     <= ST_MREQ;
              MReqValid <= 1'b1;
              MAddr     <= {Addr[AW-1:2], 2'b00};
              MWen      <= MemWr;
              MWMask    <= MemWr ? al_mask : 4'b0000;
              MWData    <= MemWr ? al_wlanes : '0;
            end
          end
        end
        ST_MREQ: begin
          if (MReqReady) begin
            state     <= ST_MWAIT;
            MReqValid <= 1'b0;
            MAddr     <= '0;
            MWen      <= 1'b0;
            MWMask    <= 4'b0000;
            MWData    <= '0;
          end
        end
        ST_MWAIT: begin
          if (MRespValid) begin
            state     <= ST_RESP;
            RespValid <= 1'b1;
            Err       <= 1'b0;
            RData     <= rd_q ? al_rext : '0;
          end
        end
        ST_RESP: begin
          if (RespReady) begin
            state     <= ST_IDLE;
            RespValid <= 1'b0;
            Err       <= 1'b0;
            RData     <= '0;
            ReqReady  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store controller between the execute stage and the data memory port. Accepts one memory operation per handshake, checks alignment, generates the word-aligned address, byte mask and lane-steered write data, waits a variable number of cycles for memory, and returns sign- or zero-extended load data to writeback. It replaces direct combinational memory access so that data memory latency is no longer fixed at zero.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; fixed at 32, 4 byte lanes.

Ports:
- `Clk`  in  1  rising-edge clock.
- `RstN`  in  1  reset; asynchronous, active-low.
- `ReqValid`  in  1  execute stage presents an operation.
- `ReqReady`  out  1  controller can accept; high only in IDLE.
- `Addr`  in  AW  byte address.
- `MemRd`  in  1  load.
- `MemWr`  in  1  store.
- `MemOp`  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- `WData`  in  DW  store data, low bits significant.
- `MReqValid`  out  1  request to memory.
- `MReqReady`  in  1  memory accepts request.
- `MAddr`  out  AW  `Addr` with bits [1:0] cleared.
- `MWen`  out  1  1 = write.
- `MWMask`  out  4  byte-lane mask; bit k = bits [8k+7:8k].
- `MWData`  out  DW  lane-steered store data.
- `MRespValid`  in  1  memory response (read data or write ack), one cycle pulse.
- `MRData`  in  DW  little-endian read word.
- `RespValid`  out  1  result to writeback.
- `RespReady`  in  1  writeback accepts.
- `RData`  out  DW  extended load data; 0 for stores and errors.
- `Err`  out  1  misaligned or illegal operation; valid with `RespValid`.

## Operation
- States: IDLE, MREQ, MWAIT, RESP.
- IDLE: `ReqReady`=1. On `ReqValid`: capture `Addr`, `MemOp`, `MemRd`, `MemWr`, `WData`. Legal -> MREQ; illegal/misaligned -> RESP with `Err`=1, no memory access.
- Illegal: `MemRd`==`MemWr`; `MemOp` in {011,110,111}; store with `MemOp` 100/101.
- Misaligned: half with `Addr[0]`=1; word with `Addr[1:0]`!=0.
- MREQ: `MReqValid`=1, outputs stable until `MReqReady`; then -> MWAIT.
- MWAIT: on `MRespValid`, register extended result (loads) -> RESP. `MRespValid` outside MWAIT is ignored.
- RESP: `RespValid`=1, `RData`/`Err` held until `RespReady`; then -> IDLE.
- Load extraction: byte = `MRData[8*off+7:8*off]`, half = `MRData[16*off[1]+15:16*off[1]]`; sign bit replicated for 000/001, zeros for 100/101.
- Store mask: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`. `MWData` = data replicated into the target lanes.

## Timing
- Reset (asynchronous, `RstN`=0): state IDLE; `ReqReady`=0 while in reset, 1 the first cycle after release; `MReqValid`, `RespValid`, `Err`, `MWen` = 0; `MWMask`, `MAddr`, `MWData`, `RData` = 0. Reset mid-transaction drops the operation; a late `MRespValid` is then ignored.
- Accept at edge N -> `MReqValid` from cycle N+1.
- Minimum load latency: zero-wait memory (`MReqReady` at N+1, `MRespValid` at N+2) -> `RespValid` at N+3.
- Error path: `RespValid` at N+1.
- Back-to-back: next accept earliest the cycle after RESP handshake (IDLE re-entry); throughput ≤ 1 op / 4 cycles.
- All outputs registered or decoded from state register only; no combinational path from `MRData` to `RData`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misaligned accesses return `Err`=1 without memory access.
- Undefined: misalignment not checked; `Addr[1:0]` forced to the natural alignment (half clears bit 0, word clears bits [1:0]) and the access proceeds; `Err` set only for illegal operations.

## Structure
- Package `lsu_pkg`: `MemOp` encodings as named constants, state enum type, lane-count constant.
- Sub-module `lsu_align`: combinational mask/write-steering and load extraction/extension from `MemOp` and offset; instantiated once in `lsu_ctrl`.

## Test plan
- Load word at 0x80000004, memory returns 0x11223344 after 0 waits -> `RData`=0x11223344, `RespValid` at accept+3, `Err`=0.
- `lb` at offset 3, `MRData`=0x80FF0000 -> `RData`=0xFFFFFF80; `lbu` same -> 0x00000080.
- `sh` 0xABCD at offset 2 -> `MWMask`=4'b1100, `MWData`[31:16]=0xABCD, `MWen`=1, `MAddr` aligned.
- `lw` at 0x80000002 with macro -> `Err`=1 at accept+1, no `MReqValid`; without macro -> access at 0x80000000.
- `MReqReady` low 3 cycles then `MRespValid` after 5 more, `RespReady` low 2 cycles -> outputs stable throughout, single response.
- `RstN` asserted in MWAIT, then late `MRespValid` -> all outputs 0, state IDLE, no `RespValid`.
